// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage with wait-stated data memory; MEMSTAGE_OVF_SQUASH_EN squashes overflowed writes
module memory_stage #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [74:0] EXMEMReg,
    output logic [70:0] MEMWBReg,
    output logic        stall
);
    localparam int A  = $clog2(MEM_WORDS);
    localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [70:0]   memwb_q, memwb_d;
    logic [31:0]   mem [MEM_WORDS] = '{default: '0};
    logic [A-1:0]  idx;
    logic [31:0]   load_data;
    logic          squash, mem_read, mem_write, reg_write, access;
    logic          unused_bits;

`ifdef MEMSTAGE_OVF_SQUASH_EN
    assign squash      = EXMEMReg[70];
    assign unused_bits = ^{EXMEMReg[69], EXMEMReg[1:0], EXMEMReg[31:A+2]};
`else
    assign squash      = 1'b0;
    assign unused_bits = ^{EXMEMReg[70:69], EXMEMReg[1:0], EXMEMReg[31:A+2]};
`endif

    assign idx       = EXMEMReg[A+1:2];
    assign mem_read  = EXMEMReg[71];
    assign mem_write = EXMEMReg[73] & ~squash;
    assign reg_write = EXMEMReg[74] & ~squash;
    assign access    = mem_read | mem_write;
    assign load_data = mem_read ? mem[idx] : '0;
    assign MEMWBReg  = memwb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            memwb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            memwb_q <= memwb_d;
        end
    end

    // Writes land only on the completion edge, so an abandoned access never reaches memory
    always_ff @(posedge clk) begin
        if (!rst && !stall && mem_write) mem[idx] <= EXMEMReg[63:32];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            if (access && (WAIT_STATES != 0)) begin
                state_d = S_WAIT;
                cnt_d   = CW'(WAIT_STATES - 1);
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        stall   = state_q == S_WAIT ? cnt_q != '0 : access && (WAIT_STATES != 0);
        memwb_d = stall ? '0 : {EXMEMReg[72], EXMEMReg[31:0], reg_write, EXMEMReg[68:64], load_data};
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vectors plus randomized ops checked against a transaction-level model
module tb_memory_stage;
    localparam int MEM_WORDS = 256;
    localparam int WS        = 2;
`ifdef MEMSTAGE_OVF_SQUASH_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [74:0] exmem = '0;
    logic [70:0] memwb;
    logic        stall;

    memory_stage #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .EXMEMReg(exmem), .MEMWBReg(memwb), .stall(stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [MEM_WORDS];

    typedef struct {
        string       name;
        logic [74:0] ex;
        logic [70:0] wb;
        int          stalls;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [74:0] mk(input logic [31:0] alu, input logic [31:0] data, input logic [4:0] dest,
                                       input logic ovf, input logic mr, input logic mtr, input logic mw, input logic rw);
        return {rw, mw, mtr, mr, ovf, 1'b0, dest, data, alu};
    endfunction

    function automatic logic [70:0] wbv(input logic mtr, input logic [31:0] alu, input logic rw,
                                        input logic [4:0] dest, input logic [31:0] ld);
        return {mtr, alu, rw, dest, ld};
    endfunction

    task automatic check(input string nm, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Whole-instruction model: memory as an array, latency from the access rule
    task automatic model(input logic [74:0] ex, output logic [70:0] wb, output int st);
        int          idx;
        logic        sq, mr, mw, rw;
        logic [31:0] ld;
        idx = int'((ex[31:0] >> 2) % MEM_WORDS);
        sq  = SQ && ex[70];
        mr  = ex[71];
        mw  = ex[73] && !sq;
        rw  = ex[74] && !sq;
        ld  = mr ? model_mem[idx] : 32'h0;
        if (mw) model_mem[idx] = ex[63:32];
        st = (mr || mw) ? WS : 0;
        wb = {ex[72], ex[31:0], rw, ex[68:64], ld};
    endtask

    task automatic run(input logic [74:0] ex, output logic [70:0] wb, output int st, output logic bub_ok);
        logic s;
        logic done;
        done   = 1'b0;
        st     = 0;
        bub_ok = 1'b1;
        wb     = '0;
        @(negedge clk);
        exmem = ex;
        for (int i = 0; i < 20; i++) begin
            #1;
            s = stall;
            @(posedge clk);
            #1;
            if (s) begin
                st++;
                if (memwb !== '0) bub_ok = 1'b0;
                @(negedge clk);
            end else begin
                wb   = memwb;
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout actual=stalled required=done");
        end
    endtask

    task automatic do_op(input string nm, input logic [74:0] ex, input logic [70:0] exp_wb, input int exp_st);
        logic [70:0] wb;
        int          st;
        logic        bub;
        run(ex, wb, st, bub);
        check({nm, "_wb"}, wb, exp_wb);
        check({nm, "_stalls"}, 71'(st), 71'(exp_st));
        check({nm, "_bubbles"}, 71'(bub), 71'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [70:0] mwb;
        int          mst;
        logic [74:0] ex;
        logic [31:0] alu;
        int          op;
        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;

        rst   = 1'b1;
        exmem = {11'($urandom), $urandom, $urandom};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        exmem = '0;
        #1;
        check("reset_memwb", memwb, '0);
        check("reset_stall", 71'(stall), '0);

        vecs.push_back('{"rtype", mk(32'd25, 32'h0, 5'd17, 0, 0, 0, 0, 1), wbv(0, 32'd25, 1, 5'd17, 32'h0), 0});
        vecs.push_back('{"sw_dead", mk(32'h64, 32'hDEADBEEF, 5'd0, 0, 0, 0, 1, 0), wbv(0, 32'h64, 0, 5'd0, 32'h0), 2});
        vecs.push_back('{"lw_dead", mk(32'h64, 32'h0, 5'd9, 0, 1, 1, 0, 1), wbv(1, 32'h64, 1, 5'd9, 32'hDEADBEEF), 2});
        vecs.push_back('{"sw_wrap", mk(32'h400, 32'd7, 5'd0, 0, 0, 0, 1, 0), wbv(0, 32'h400, 0, 5'd0, 32'h0), 2});
        vecs.push_back('{"lw_wrap", mk(32'h0, 32'h0, 5'd3, 0, 1, 1, 0, 1), wbv(1, 32'h0, 1, 5'd3, 32'd7), 2});
        vecs.push_back('{"ovf_sw", mk(32'h20, 32'h99, 5'd4, 1, 0, 0, 1, 1), wbv(0, 32'h20, !SQ, 5'd4, 32'h0), SQ ? 0 : 2});
        vecs.push_back('{"lw_ovf_chk", mk(32'h20, 32'h0, 5'd5, 0, 1, 1, 0, 1), wbv(1, 32'h20, 1, 5'd5, SQ ? 32'h0 : 32'h99), 2});
        vecs.push_back('{"ovf_lw", mk(32'h20, 32'h0, 5'd6, 1, 1, 1, 0, 1), wbv(1, 32'h20, !SQ, 5'd6, SQ ? 32'h0 : 32'h99), 2});
        vecs.push_back('{"rw_both", mk(32'h64, 32'h12345678, 5'd2, 0, 1, 1, 1, 1), wbv(1, 32'h64, 1, 5'd2, 32'hDEADBEEF), 2});
        vecs.push_back('{"lw_low_bits", mk(32'h67, 32'h0, 5'd1, 0, 1, 1, 0, 1), wbv(1, 32'h67, 1, 5'd1, 32'h12345678), 2});

        foreach (vecs[i]) begin
            model(vecs[i].ex, mwb, mst);
            do_op(vecs[i].name, vecs[i].ex, vecs[i].wb, vecs[i].stalls);
        end

        // Reset while the store is waiting: the write must be abandoned
        @(negedge clk);
        exmem = mk(32'h10, 32'h55, 5'd0, 0, 0, 0, 1, 0);
        #1;
        check("midrst_stall", 71'(stall), 71'(1));
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        exmem = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_memwb", memwb, '0);
        check("midrst_idle_stall", 71'(stall), '0);
        do_op("midrst_load", mk(32'h10, 32'h0, 5'd7, 0, 1, 1, 0, 1), wbv(1, 32'h10, 1, 5'd7, 32'h0), WS);

        for (int i = 0; i < 200; i++) begin
            alu = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            op  = int'($urandom_range(0, 3));
            ex  = mk(alu, $urandom, 5'($urandom), $urandom_range(0, 7) == 0, op == 1 || op == 3,
                     1'($urandom), op >= 2, 1'($urandom));
            model(ex, mwb, mst);
            do_op($sformatf("rand%0d", i), ex, mwb, mst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
